// File: rtl/inst_ram_sync_if.sv
// Fetch and programming-port bundle for the instruction memory.
// master = IF stage / loader side, slave = the memory.
interface inst_ram_sync_if #(
   parameter int W = 32
);
   logic [W-1:0]   pc;
   logic           fetch_req;
   logic           fetch_stall;
   logic           fetch_ready;
   logic [W-1:0]   inst_data;
   logic           inst_valid;
   logic           fetch_err;
   logic           load_valid;
   logic           load_ready;
   logic [W-1:0]   load_addr;
   logic [W-1:0]   load_data;
   logic [W/8-1:0] load_be;
   logic           load_err;
   logic           init_done;

   modport master (
      output pc, fetch_req, fetch_stall, load_valid, load_addr, load_data, load_be,
      input  fetch_ready, inst_data, inst_valid, fetch_err, load_ready, load_err, init_done
   );

   modport slave (
      input  pc, fetch_req, fetch_stall, load_valid, load_addr, load_data, load_be,
      output fetch_ready, inst_data, inst_valid, fetch_err, load_ready, load_err, init_done
   );
endinterface

// File: rtl/inst_ram_sync.sv
// Synchronous-read instruction memory: registered fetch port with error flag,
// byte-strobed programming port (write-first on collision), optional post-reset clear.
module inst_ram_sync #(
   parameter int            W          = 32,
   parameter int            DEPTH      = 2048,
   parameter bit            INIT_CLEAR = 1'b1,
   parameter string         INIT_FILE  = "",
   parameter logic [W-1:0]  NOP        = W'(32'h00000013)
) (
   input  logic           clk,
   input  logic           rst_n,
   inst_ram_sync_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB = W / 8;

   typedef enum logic {INIT, RUN} state_t;

   state_t        state;
   logic [AW-1:0] clr_cnt;
   logic [W-1:0]  mem [DEPTH];

   function automatic logic [W-1:0] merge_bytes(input logic [W-1:0]  old_w,
                                                 input logic [W-1:0]  new_w,
                                                 input logic [NB-1:0] be);
      logic [W-1:0] r;
      r = old_w;
      for (int i = 0; i < NB; i++)
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // Out-of-range indices are rejected rather than wrapped onto the array.
   function automatic logic addr_bad(input logic [W-1:0] a);
      return (a[1:0] != 2'b00) || ((a >> 2) >= W'(DEPTH));
   endfunction

   logic          run;
   logic          fetch_bad;
   logic          load_ok;
   logic          fwd_hit;
   logic [AW-1:0] fetch_idx;
   logic [AW-1:0] load_idx;
   logic [W-1:0]  rd_word;

   assign run             = (state == RUN);
   assign bus.fetch_ready = run && !bus.fetch_stall;
   assign bus.load_ready  = run;

   assign fetch_idx = AW'(bus.pc >> 2);
   assign load_idx  = AW'(bus.load_addr >> 2);
   assign fetch_bad = addr_bad(bus.pc);
   assign load_ok   = bus.load_valid && run && !addr_bad(bus.load_addr);
   assign fwd_hit   = load_ok && (load_idx == fetch_idx);
   assign rd_word   = fwd_hit ? merge_bytes(mem[fetch_idx], bus.load_data, bus.load_be)
                              : mem[fetch_idx];

   // Array write port: clear sweep during INIT, loader writes in RUN.
   always_ff @(posedge clk) begin
      if (!run && INIT_CLEAR)
         mem[clr_cnt] <= '0;
      else if (load_ok)
         mem[load_idx] <= merge_bytes(mem[load_idx], bus.load_data, bus.load_be);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= INIT;
         clr_cnt        <= '0;
         bus.inst_data  <= NOP;
         bus.inst_valid <= 1'b0;
         bus.fetch_err  <= 1'b0;
         bus.load_err   <= 1'b0;
         bus.init_done  <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               bus.load_err <= 1'b0;
               clr_cnt      <= clr_cnt + AW'(1);
               if (!INIT_CLEAR || clr_cnt == AW'(DEPTH - 1)) begin
                  state         <= RUN;
                  bus.init_done <= 1'b1;
               end
            end
            RUN: begin
               bus.load_err <= bus.load_valid && addr_bad(bus.load_addr);
               // A stalled consumer sees the previous result frozen.
               if (!bus.fetch_stall) begin
                  bus.inst_valid <= bus.fetch_req;
                  bus.fetch_err  <= bus.fetch_req && fetch_bad;
                  if (bus.fetch_req)
                     bus.inst_data <= fetch_bad ? NOP : rd_word;
               end
            end
            default: state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_ram_sync.sv
// Randomised scoreboard bench for inst_ram_sync (DEPTH=16, INIT_CLEAR=1).
module tb_inst_ram_sync;
   localparam int          W     = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inst_ram_sync_if #(.W(W)) bus ();

   inst_ram_sync #(
      .W(W), .DEPTH(DEPTH), .INIT_CLEAR(1'b1), .INIT_FILE(""), .NOP(NOP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } resp_t;

   resp_t       exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] ref_mem [DEPTH];
   logic        mv;
   logic        me;
   logic [31:0] md;
   logic        mon_held;
   logic        mon_rst;
   resp_t       mon_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit bad_addr(input logic [31:0] a);
      return (a % 4 != 0) || (a / 4 >= DEPTH);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      mv = 1'b0; me = 1'b0; md = NOP;
      exp_q.delete();
   endtask

   // Monitor: every unstalled edge must present exactly the pending response.
   always begin
      @(posedge clk);
      mon_held = bus.fetch_stall;
      mon_rst  = rst_n;
      #2;
      if (mon_rst && rst_n && !mon_held) begin
         check("fetch_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            mon_r = exp_q.pop_front();
            if (bus.inst_valid) begin
               check("fetch_data", bus.inst_data, mon_r.data);
               check("fetch_err", 32'(bus.fetch_err), 32'(mon_r.err));
            end
         end
      end
   end

   task automatic step(input logic fr, input logic [31:0] pc, input logic st,
                       input logic lv, input logic [31:0] la, input logic [31:0] ld,
                       input logic [3:0] be);
      logic exp_lerr;
      resp_t r;
      @(negedge clk);
      bus.fetch_req = fr; bus.pc = pc; bus.fetch_stall = st;
      bus.load_valid = lv; bus.load_addr = la; bus.load_data = ld; bus.load_be = be;
      #1;
      check("fetch_ready", 32'(bus.fetch_ready), 32'(!st));
      check("load_ready", 32'(bus.load_ready), 32'd1);
      exp_lerr = lv && bad_addr(la);
      if (lv && !exp_lerr)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[la / 4][8*b +: 8] = ld[8*b +: 8];
      if (!st) begin
         mv = fr;
         me = fr && bad_addr(pc);
         if (fr) begin
            md = bad_addr(pc) ? NOP : ref_mem[pc / 4];
            r.data = md; r.err = me;
            exp_q.push_back(r);
         end
      end
      @(posedge clk);
      #1;
      check("load_err", 32'(bus.load_err), 32'(exp_lerr));
      if (st) begin
         check("stall_valid", 32'(bus.inst_valid), 32'(mv));
         check("stall_err", 32'(bus.fetch_err), 32'(me));
         if (mv) check("stall_data", bus.inst_data, md);
      end
   endtask

   task automatic wait_init();
      int n;
      bit done;
      n = 0; done = 0;
      bus.fetch_req = 1'b1; bus.pc = 32'h0; bus.fetch_stall = 1'b0;
      bus.load_valid = 1'b1; bus.load_addr = 32'h4; bus.load_data = $urandom; bus.load_be = 4'hF;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.init_done) done = 1;
         else check("init_load_err", 32'(bus.load_err), 32'd0);
      end
      check("init_cycles", 32'(n), 32'(DEPTH));
   endtask

   task automatic sweep();
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, DEPTH + 2) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      bus.fetch_req = 1'b0; bus.pc = '0; bus.fetch_stall = 1'b0;
      bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.load_be = '0;
      model_reset();

      @(posedge clk);
      #1;
      check("rst_inst_data", bus.inst_data, NOP);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
      check("rst_load_err", 32'(bus.load_err), 32'd0);
      check("rst_init_done", 32'(bus.init_done), 32'd0);
      check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
      check("rst_load_ready", 32'(bus.load_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init();

      step(1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
      step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("load_then_fetch", bus.inst_data, 32'hDEADBEEF);
      step(1'b1, 32'h8, 1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101);
      check("forward_merge", bus.inst_data, 32'hDE22BE44);
      step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'(i * 4 + 16), 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      check("stall_hold", bus.inst_data, 32'hDE22BE44);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("misaligned_nop", bus.inst_data, NOP);
      step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h5, 32'hCAFEF00D, 4'hF);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 32'hCAFEF00D, 4'h0);
      sweep();

      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 9) < 7), rand_addr(), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 9) < 4), rand_addr(), $urandom, 4'($urandom));
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      sweep();

      @(negedge clk);
      bus.fetch_req = 1'b1; bus.pc = 32'h8; bus.fetch_stall = 1'b0;
      bus.load_valid = 1'b1; bus.load_addr = 32'h10; bus.load_data = 32'h12345678; bus.load_be = 4'hF;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("midrst_inst_data", bus.inst_data, NOP);
      check("midrst_fetch_err", 32'(bus.fetch_err), 32'd0);
      check("midrst_init_done", 32'(bus.init_done), 32'd0);
      check("midrst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
      check("midrst_load_ready", 32'(bus.load_ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init();
      sweep();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
